alarmclock_mem_arbiter: RTL

ALARMCLOCK_MEM_ARBITER -- requirements
Module: alarmclock_mem_arbiter

---
 rtl/alarmclock_mem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alarmclock_mem_arbiter.sv
// Two-master arbiter in front of a single-port RAM with 1-cycle read latency and lock hold.
// Define ALARMCLOCK_MEM_ARB_FIXED_PRIO_EN for fixed priority (m0 over m1); default is round-robin.
module alarmclock_mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic                m0_lock,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic                m1_lock,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state;
    logic   rvld0, rvld1;
    logic   req0, req1, gnt0, gnt1;
`ifndef ALARMCLOCK_MEM_ARB_FIXED_PRIO_EN
    logic   last_grant;
`endif

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            case (state)
                OWN0: gnt0 = req0;
                OWN1: gnt1 = req1;
                default: begin
`ifdef ALARMCLOCK_MEM_ARB_FIXED_PRIO_EN
                    gnt0 = req0;
                    gnt1 = req1 & ~req0;
`else
                    // On a tie the master that did not win last time goes first.
                    if (req0 && req1) begin
                        gnt0 = last_grant;
                        gnt1 = ~last_grant;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
`endif
                end
            endcase
        end
    end

    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;

    assign mem_chipselect = gnt0 | gnt1;
    assign mem_clken      = reset_n;
    assign mem_address    = gnt1 ? m1_address    : m0_address;
    assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
    assign mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);

    // Gating with reset_n hides a read accepted just before reset asserts.
    assign m0_readdatavalid = rvld0 & reset_n;
    assign m1_readdatavalid = rvld1 & reset_n;
    assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
    assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            rvld0 <= 1'b0;
            rvld1 <= 1'b0;
`ifndef ALARMCLOCK_MEM_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            rvld0 <= gnt0 & m0_read & ~m0_write;
            rvld1 <= gnt1 & m1_read & ~m1_write;
`ifndef ALARMCLOCK_MEM_ARB_FIXED_PRIO_EN
            if (gnt0 || gnt1)
                last_grant <= gnt1;
`endif
            case (state)
                IDLE: begin
                    if (gnt0 && m0_lock)
                        state <= OWN0;
                    else if (gnt1 && m1_lock)
                        state <= OWN1;
                end
                OWN0: if (gnt0 && !m0_lock) state <= IDLE;
                OWN1: if (gnt1 && !m1_lock) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
